// File: rtl/regfile_context_engine.sv
// regfile_context_engine
// Initiator-side controller for the 16x32 secure register file. It performs three
// commanded operations:
//   SAVE    - stream every register out over the out_* handshake
//   RESTORE - stream every register in over the in_* handshake
//   SCRUB   - zeroize every entry
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready/op  command handshake (op 00=SAVE, 01=RESTORE, 10=SCRUB, 11=illegal)
//   busy, done, err     status: busy level, one-cycle done pulse, err pulse with done
//   rf_write_*          register-file write port (data forced to 0 when not writing)
//   rf_read_addr/data   register-file read port, data valid one cycle after address
//   out_valid/ready/data SAVE stream (registered, held stable under backpressure)
//   in_valid/ready/data  RESTORE stream (in_ready high throughout RESTORE)
//
// Optional feature: define SCRUB_ON_RESET_EN to scrub the whole file automatically
// once rst deasserts; no command is accepted until that scrub has finished.
module regfile_context_engine #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data
);

    typedef enum logic [2:0] {
        StIdle,
        StSaveAddr,
        StSaveCap,
        StSaveOut,
        StRestore,
        StScrub,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                boot_pending;
    logic                last_idx;

`ifdef SCRUB_ON_RESET_EN
    // Set by reset; the first cycle out of reset launches the scrub instead of
    // offering cmd_ready.
    logic boot_q, boot_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            boot_q <= 1'b1;
        end else begin
            boot_q <= boot_d;
        end
    end

    assign boot_pending = boot_q;
    assign boot_d       = 1'b0;
`else
    assign boot_pending = 1'b0;
`endif

    assign last_idx = (index_q == LastIdx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            index_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        index_d         = index_q;
        busy_d          = busy_q;
        err_d           = err_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        cmd_ready       = 1'b0;
        done            = 1'b0;
        err             = 1'b0;
        rf_write_enable = 1'b0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        rf_read_addr    = '0;
        in_ready        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (boot_pending) begin
                    index_d = '0;
                    busy_d  = 1'b1;
                    state_d = StScrub;
                end else begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        index_d = '0;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        unique case (cmd_op)
                            2'b00:   state_d = StSaveAddr;
                            2'b01:   state_d = StRestore;
                            2'b10:   state_d = StScrub;
                            default: begin
                                err_d   = 1'b1;
                                state_d = StDone;
                            end
                        endcase
                    end
                end
            end
            StSaveAddr: begin
                rf_read_addr = index_q;
                state_d      = StSaveCap;
            end
            StSaveCap: begin
                // Read data for the address presented last cycle is valid now.
                out_data_d  = rf_read_data;
                out_valid_d = 1'b1;
                state_d     = StSaveOut;
            end
            StSaveOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    if (last_idx) begin
                        state_d = StDone;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = StSaveAddr;
                    end
                end
            end
            StRestore: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rf_write_enable = 1'b1;
                    rf_write_addr   = index_q;
                    rf_write_data   = in_data;
                    if (last_idx) begin
                        state_d = StDone;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                    end
                end
            end
            StScrub: begin
                rf_write_enable = 1'b1;
                rf_write_addr   = index_q;
                if (last_idx) begin
                    state_d = StDone;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                err     = err_q;
                busy_d  = 1'b0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
